// File: rtl/sub_pkg.sv
// ---------------------------------------------------------------------------
// sub_pkg
// Shared definitions for the bit-serial subtractor:
//   state_t : controller states (IDLE, RUN, DONE)
//   SUB_W   : default operand/result width
// ---------------------------------------------------------------------------
package sub_pkg;

    localparam int SUB_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_sub.sv
// ---------------------------------------------------------------------------
// full_sub
// One-bit full subtractor cell: d = x - y - z, with borrow-out bo.
// Ports:
//   x  : minuend bit
//   y  : subtrahend bit
//   z  : borrow-in
//   d  : difference bit
//   bo : borrow-out
// ---------------------------------------------------------------------------
module full_sub (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ z;
    // Borrow when y alone exceeds x, or when x == y and a borrow comes in.
    assign bo = (~x & y) | (~(x ^ y) & z);

endmodule

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
// Bit-serial W-bit subtractor: diff = (a - b - bin) mod 2^W, bout = borrow.
// Processes one bit per clock, LSB first, through a single full_sub cell.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (ready only when idle)
//   a, b, bin            : minuend, subtrahend, borrow-in
//   out_valid / out_ready: result handshake (valid only when done)
//   diff, bout           : registered result and borrow-out
// ---------------------------------------------------------------------------
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int W = SUB_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] diff,
    output logic         bout
);

    localparam int            CW   = $clog2(W + 1);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_t        state_q, state_d;
    logic [W-1:0]  sa_q, sa_d;
    logic [W-1:0]  sb_q, sb_d;
    logic [W-1:0]  diff_q, diff_d;
    logic          borrow_q, borrow_d;
    logic          bout_q, bout_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cell_d;
    logic          cell_bo;

    full_sub u_cell (
        .x  (sa_q[0]),
        .y  (sb_q[0]),
        .z  (borrow_q),
        .d  (cell_d),
        .bo (cell_bo)
    );

    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sa_d     = a;
                    sb_d     = b;
                    borrow_d = bin;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                sa_d        = sa_q >> 1;
                sb_d        = sb_q >> 1;
                // Result bits enter at the MSB so after W shifts bit 0 sits at LSB.
                diff_d      = diff_q >> 1;
                diff_d[W-1] = cell_d;
                borrow_d    = cell_bo;
                cnt_d       = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    bout_d  = cell_bo;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
            cnt_q    <= cnt_d;
        end
    end

    // Operand shift registers only matter once loaded, so they skip reset.
    always_ff @(posedge clk) begin
        sa_q <= sa_d;
        sb_q <= sb_d;
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign bout      = bout_q;

endmodule
